// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar trigger/echo controller: FSM state
// encodings, default timing constants and width helper functions.
package sonar_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_TRIG      = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_RISE = 3'd2;
  localparam logic [ST_W-1:0] ST_MEASURE   = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE      = 3'd4;
  localparam logic [ST_W-1:0] ST_HOLDOFF   = 3'd5;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_TRIG_CYCLES  = 10;
  localparam int unsigned DEF_RISE_TIMEOUT = 1000;
  localparam int unsigned DEF_HOLDOFF      = 64;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to represent the value v.
  function automatic int unsigned bits_for(input int unsigned v);
    return (v > 1) ? $clog2(v + 1) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sonar_echo_timer.sv
// Saturating up-counter with a limit compare; one instance is time-shared
// for trigger width, echo-rise timeout, echo length and holdoff timing.
module sonar_echo_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         limit_hit_c
);

  logic [W-1:0] count_q, count_d;

  // Load has priority; increment stops at all-ones so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o     = count_q;
  assign limit_hit_c = (count_q >= limit_i);

endmodule

// File: rtl/sonar_trigger_ctrl.sv
// Round-robin ultrasonic trigger/echo controller. Fires one sensor at a
// time, times its echo-high interval and reports it with the channel index.
// Optional macro SONAR_ECHO_SYNC_EN adds a 2-flop synchronizer on ECHO.
module sonar_trigger_ctrl
  import sonar_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int unsigned RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter int unsigned ECHO_MAX     = (32'd1 << CNT_W) - 32'd1,
  parameter int unsigned HOLDOFF      = DEF_HOLDOFF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          TRIG_EN,
  input  logic                          TRIG,
  input  logic [NUM_CH-1:0]             ECHO,
  output logic [NUM_CH-1:0]             SR_TRIG,
  output logic                          MEAS_RESET,
  output logic                          MEAS_READY,
  output logic                          MEAS_VALID,
  output logic                          MEAS_TIMEOUT,
  output logic [ch_width(NUM_CH)-1:0]   MEAS_CH,
  output logic [CNT_W-1:0]              MEAS_VALUE
);

  localparam int unsigned CH_W     = ch_width(NUM_CH);
  // DONE registers the result one cycle after WAIT_RISE exits, so the
  // rise limit is one short to land MEAS_VALID RISE_TIMEOUT clocks out.
  localparam int unsigned RISE_LIM = (RISE_TIMEOUT > 1) ? RISE_TIMEOUT - 1 : 1;
  localparam int unsigned TRIG_LIM = (TRIG_CYCLES > 0) ? TRIG_CYCLES : 1;
  localparam int unsigned HOLD_LIM = (HOLDOFF > 0) ? HOLDOFF : 1;
  localparam int unsigned TMR_W    = max_u(CNT_W, max_u(bits_for(RISE_LIM),
                                     max_u(bits_for(HOLD_LIM), bits_for(TRIG_LIM))));

  logic [NUM_CH-1:0] echo_s;

`ifdef SONAR_ECHO_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous echo inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ECHO;
      sync2_q <= sync1_q;
    end
  end
  assign echo_s = sync2_q;
`else
  assign echo_s = ECHO;
`endif

  logic [ST_W-1:0]   state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] sr_trig_q, sr_trig_d;
  logic              meas_reset_q, meas_reset_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              tmo_q, tmo_d;
  logic              tmo_pend_q, tmo_pend_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  value_q, value_d;

  logic              tmr_load, tmr_inc, tmr_hit;
  logic [TMR_W-1:0]  tmr_load_val, tmr_limit, tmr_count;
  logic              echo_sel;

  assign echo_sel = echo_s[ptr_q];

  sonar_echo_timer #(.W(TMR_W)) u_timer (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .load_i      (tmr_load),
    .load_val_i  (tmr_load_val),
    .inc_i       (tmr_inc),
    .limit_i     (tmr_limit),
    .count_o     (tmr_count),
    .limit_hit_c (tmr_hit)
  );

  // Next-state, timer control and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sr_trig_d    = sr_trig_q;
    meas_reset_d = 1'b0;
    ready_d      = ready_q;
    valid_d      = 1'b0;
    tmo_d        = tmo_q;
    tmo_pend_d   = tmo_pend_q;
    ch_d         = ch_q;
    value_d      = value_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_inc      = 1'b0;
    tmr_limit    = TMR_W'(HOLD_LIM);

    case (state_q)
      ST_IDLE: begin
        if (TRIG && TRIG_EN) begin
          state_d      = ST_TRIG;
          sr_trig_d    = NUM_CH'(1) << ptr_q;
          meas_reset_d = 1'b1;
          ready_d      = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(1);
        end
      end
      ST_TRIG: begin
        tmr_limit = TMR_W'(TRIG_LIM);
        if (tmr_hit) begin
          state_d      = ST_WAIT_RISE;
          sr_trig_d    = '0;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(1);
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        tmr_limit = TMR_W'(RISE_LIM);
        if (echo_sel) begin
          state_d      = ST_MEASURE;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(1);
        end else if (tmr_hit) begin
          state_d      = ST_DONE;
          tmo_pend_d   = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = '0;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_MEASURE: begin
        tmr_limit = TMR_W'(ECHO_MAX);
        if (!echo_sel) begin
          state_d    = ST_DONE;
          tmo_pend_d = 1'b0;
        end else if (tmr_hit) begin
          state_d    = ST_DONE;
          tmo_pend_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_DONE: begin
        valid_d      = 1'b1;
        value_d      = CNT_W'(tmr_count);
        tmo_d        = tmo_pend_q;
        ch_d         = ptr_q;
        ptr_d        = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + CH_W'(1);
        state_d      = ST_HOLDOFF;
        tmr_load     = 1'b1;
        tmr_load_val = TMR_W'(1);
      end
      ST_HOLDOFF: begin
        if (tmr_hit) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sr_trig_d = '0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any measurement in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      sr_trig_q    <= '0;
      meas_reset_q <= 1'b0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      tmo_q        <= 1'b0;
      tmo_pend_q   <= 1'b0;
      ch_q         <= '0;
      value_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sr_trig_q    <= sr_trig_d;
      meas_reset_q <= meas_reset_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      tmo_q        <= tmo_d;
      tmo_pend_q   <= tmo_pend_d;
      ch_q         <= ch_d;
      value_q      <= value_d;
    end
  end

  assign SR_TRIG      = sr_trig_q;
  assign MEAS_RESET   = meas_reset_q;
  assign MEAS_READY   = ready_q;
  assign MEAS_VALID   = valid_q;
  assign MEAS_TIMEOUT = tmo_q;
  assign MEAS_CH      = ch_q;
  assign MEAS_VALUE   = value_q;

endmodule
